// File: rtl/cpu_ctrl_seq_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_seq_pkg
// Shared types for the accumulator CPU control sequencer:
//   opcode_t        - 3-bit instruction opcode held in the IR
//   phase_t         - 3-bit sequencer phase, in execution order
//   ctrl_strobes_t  - bundle of datapath strobes produced by the decoder
//   is_aluop()      - true for opcodes that read memory and load ACC
// ---------------------------------------------------------------------------
package cpu_ctrl_seq_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  typedef struct packed {
    logic mem_rd;
    logic load_ir;
    logic inc_pc;
    logic load_ac;
    logic load_pc;
    logic mem_wr;
    logic data_e;
  } ctrl_strobes_t;

  // Opcodes that fetch an operand from memory and write the ALU result to ACC.
  function automatic logic is_aluop(input opcode_t op);
    logic r;
    case (op)
      ADD, AND, XOR, LDA: r = 1'b1;
      default:            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_ctrl_seq_phase_counter.sv
// ---------------------------------------------------------------------------
// ctrl_phase_counter
// 3-bit instruction phase counter. Advances one phase per clock and wraps
// from STORE back to INST_ADDR; holds its value while frozen.
// Ports:
//   clk       in   clock, state on posedge
//   rst_      in   asynchronous active-low reset (phase -> INST_ADDR)
//   i_freeze  in   hold current phase
//   o_phase   out  current phase
//   o_wrap    out  high during the cycle whose posedge wraps STORE->INST_ADDR
// ---------------------------------------------------------------------------
module ctrl_phase_counter
  import cpu_ctrl_seq_pkg::*;
(
  input  logic   clk,
  input  logic   rst_,
  input  logic   i_freeze,
  output phase_t o_phase,
  output logic   o_wrap
);

  phase_t r_phase;

  // Phase register: increments modulo 8 unless frozen.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_phase <= INST_ADDR;
    end else if (!i_freeze) begin
      r_phase <= phase_t'(r_phase + 3'd1);
    end else begin
      r_phase <= r_phase;
    end
  end

  assign o_phase = r_phase;
  assign o_wrap  = (r_phase == STORE) && !i_freeze;

endmodule

// File: rtl/cpu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_seq
// 8-phase instruction sequencer for the 8-bit accumulator CPU. Decodes the
// current phase, opcode and ALU zero flag into datapath strobes, latches a
// sticky halt on HLT and counts retired instructions (saturating).
// Parameters:
//   CNT_W      width of the retired-instruction counter
// Ports:
//   clk        in   clock, all state on posedge
//   rst_       in   asynchronous active-low reset
//   opcode     in   opcode from instruction register
//   zero       in   ALU zero flag
//   mem_rd     out  memory read enable
//   load_ir    out  load instruction register
//   halt       out  CPU halted (sticky until reset)
//   inc_pc     out  increment program counter
//   load_ac    out  load accumulator from ALU output
//   load_pc    out  load PC from IR operand
//   mem_wr     out  memory write strobe
//   data_e     out  drive ALU output onto data bus
//   phase      out  current phase (debug)
//   instr_cnt  out  instructions retired since reset, saturating
// ---------------------------------------------------------------------------
module cpu_ctrl_seq
  import cpu_ctrl_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  opcode_t          opcode,
  input  logic             zero,
  output logic             mem_rd,
  output logic             load_ir,
  output logic             halt,
  output logic             inc_pc,
  output logic             load_ac,
  output logic             load_pc,
  output logic             mem_wr,
  output logic             data_e,
  output phase_t           phase,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  phase_t            w_phase;
  logic              w_wrap;
  logic              w_aluop;
  logic              w_halt_set;
  ctrl_strobes_t     w_strb;
  logic              r_halt;
  logic [CNT_W-1:0]  r_cnt;

  // The halt latch doubles as the freeze: the counter still steps out of
  // OP_ADDR on the setting edge, so the machine parks in OP_FETCH.
  ctrl_phase_counter u_phase_counter (
    .clk      (clk),
    .rst_     (rst_),
    .i_freeze (r_halt),
    .o_phase  (w_phase),
    .o_wrap   (w_wrap)
  );

  assign w_aluop    = is_aluop(opcode);
  assign w_halt_set = (w_phase == OP_ADDR) && (opcode == HLT);

  // Sticky halt: set leaving OP_ADDR on HLT, cleared only by reset.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_halt <= 1'b0;
    end else if (w_halt_set) begin
      r_halt <= 1'b1;
    end else begin
      r_halt <= r_halt;
    end
  end

  // Retired-instruction counter: bumps on each STORE wrap, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_cnt <= '0;
    end else if (w_wrap && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Strobe decode from registered phase plus live opcode/zero; all quiet once halted.
  always_comb begin
    w_strb = '0;
    if (r_halt) begin
      w_strb = '0;
    end else begin
      case (w_phase)
        INST_ADDR: begin
          w_strb = '0;
        end
        INST_FETCH: begin
          w_strb.mem_rd = 1'b1;
        end
        INST_LOAD, IDLE: begin
          w_strb.mem_rd  = 1'b1;
          w_strb.load_ir = 1'b1;
        end
        OP_ADDR: begin
          w_strb.inc_pc = 1'b1;
        end
        OP_FETCH: begin
          w_strb.mem_rd = w_aluop;
        end
        ALU_OP: begin
          w_strb.mem_rd  = w_aluop;
          w_strb.load_ac = w_aluop;
          w_strb.inc_pc  = (opcode == SKZ) && zero;
          w_strb.load_pc = (opcode == JMP);
          w_strb.data_e  = (opcode == STO);
        end
        STORE: begin
          w_strb.mem_rd  = w_aluop;
          w_strb.load_ac = w_aluop;
          w_strb.inc_pc  = (opcode == JMP);
          w_strb.load_pc = (opcode == JMP);
          w_strb.mem_wr  = (opcode == STO);
          w_strb.data_e  = (opcode == STO);
        end
        default: begin
          w_strb = '0;
        end
      endcase
    end
  end

  assign mem_rd    = w_strb.mem_rd;
  assign load_ir   = w_strb.load_ir;
  assign inc_pc    = w_strb.inc_pc;
  assign load_ac   = w_strb.load_ac;
  assign load_pc   = w_strb.load_pc;
  assign mem_wr    = w_strb.mem_wr;
  assign data_e    = w_strb.data_e;
  assign halt      = r_halt;
  assign phase     = w_phase;
  assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl_seq
// Self-checking bench for cpu_ctrl_seq. A behavioural model (integer phase,
// halt flag and saturating count, strobes from phase ranges) is compared
// against the DUT after every clock. A second instance with CNT_W=2 covers
// counter saturation.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl_seq;
  import cpu_ctrl_seq_pkg::*;

  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_;
  opcode_t          opcode;
  logic             zero;
  logic             mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e;
  phase_t           phase;
  logic [CNT_W-1:0] instr_cnt;

  logic             rst2_;
  opcode_t          opcode2;
  logic             zero2;
  logic             mem_rd2, load_ir2, halt2, inc_pc2, load_ac2, load_pc2, mem_wr2, data_e2;
  phase_t           phase2;
  logic [1:0]       instr_cnt2;

  int    checks = 0;
  int    errors = 0;
  int    m_phase;
  bit    m_halt;
  int    m_cnt;
  string cur_tag;

  cpu_ctrl_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
    .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt), .inc_pc(inc_pc),
    .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr), .data_e(data_e),
    .phase(phase), .instr_cnt(instr_cnt)
  );

  cpu_ctrl_seq #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_(rst2_), .opcode(opcode2), .zero(zero2),
    .mem_rd(mem_rd2), .load_ir(load_ir2), .halt(halt2), .inc_pc(inc_pc2),
    .load_ac(load_ac2), .load_pc(load_pc2), .mem_wr(mem_wr2), .data_e(data_e2),
    .phase(phase2), .instr_cnt(instr_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected strobes {mem_rd,load_ir,inc_pc,load_ac,load_pc,mem_wr,data_e}.
  function automatic logic [6:0] exp_strb(input int p, input int op, input bit z, input bit h);
    bit alu;
    bit mr, ir, ip, la, lp, mw, de;
    alu = (op >= 2) && (op <= 5);
    mr  = ((p >= 1 && p <= 3) || (p >= 5 && alu));
    ir  = (p == 2 || p == 3);
    ip  = (p == 4) || (p == 6 && op == 1 && z) || (p == 7 && op == 7);
    la  = (p >= 6) && alu;
    lp  = (p >= 6) && (op == 7);
    mw  = (p == 7) && (op == 6);
    de  = (p >= 6) && (op == 6);
    if (h) return 7'd0;
    return {mr, ir, ip, la, lp, mw, de};
  endfunction

  task automatic check_main();
    chk({cur_tag, ".phase"}, 32'(phase), 32'(m_phase));
    chk({cur_tag, ".halt"},  32'(halt),  32'(m_halt));
    chk({cur_tag, ".cnt"},   32'(instr_cnt), 32'(m_cnt));
    chk({cur_tag, ".strb"},
        32'({mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr, data_e}),
        32'(exp_strb(m_phase, int'(opcode), zero, m_halt)));
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_halt  = 1'b0;
    m_cnt   = 0;
  endtask

  // One clock: advance the model with inputs seen at the edge, then check.
  task automatic tick();
    @(posedge clk);
    if (!rst_) begin
      model_reset();
    end else if (m_halt) begin
      m_phase = m_phase;
    end else if (m_phase == 4 && int'(opcode) == 0) begin
      m_halt  = 1'b1;
      m_phase = 5;
    end else if (m_phase == 7) begin
      m_phase = 0;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_phase++;
    end
    #1;
    check_main();
  endtask

  // zmode 0/1: constant zero flag; 2: random zero every cycle.
  task automatic run_instr(input opcode_t op, input int zmode);
    opcode = op;
    for (int i = 0; i < 8; i++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      tick();
    end
  endtask

  int exp_cnt2 [5] = '{1, 2, 3, 3, 3};
  int saved_cnt;

  initial begin
    rst_    = 1'b0;
    rst2_   = 1'b0;
    opcode  = LDA;
    zero    = 1'b0;
    opcode2 = ADD;
    zero2   = 1'b0;
    model_reset();

    cur_tag = "reset";
    repeat (2) tick();

    @(negedge clk);
    rst_ = 1'b1;

    cur_tag = "lda";
    run_instr(LDA, 0);
    chk("lda.cnt_after_wrap", 32'(instr_cnt), 32'd1);

    cur_tag = "skz_z1";
    run_instr(SKZ, 1);
    cur_tag = "skz_z0";
    run_instr(SKZ, 0);
    cur_tag = "sto";
    run_instr(STO, 0);
    cur_tag = "jmp";
    run_instr(JMP, 0);

    cur_tag = "random";
    repeat (40) run_instr(opcode_t'(3'($urandom_range(1, 7))), 2);

    // Abort an ADD in ALU_OP with an asynchronous reset.
    cur_tag = "rst_mid";
    opcode = ADD;
    zero   = 1'b0;
    repeat (6) tick();
    chk("rst_mid.in_alu_op", 32'(phase), 32'(ALU_OP));
    rst_ = 1'b0;
    #1;
    model_reset();
    check_main();
    chk("rst_mid.cnt_cleared", 32'(instr_cnt), 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    cur_tag = "post_rst";
    run_instr(LDA, 0);

    // HLT: parks in OP_FETCH with everything quiet, counter untouched.
    cur_tag   = "hlt";
    saved_cnt = m_cnt;
    opcode    = HLT;
    zero      = 1'b0;
    repeat (5) tick();
    chk("hlt.phase5", 32'(phase), 32'(OP_FETCH));
    for (int i = 0; i < 20; i++) begin
      opcode = opcode_t'(3'($urandom_range(0, 7)));
      zero   = 1'($urandom_range(0, 1));
      tick();
    end
    chk("hlt.sticky", 32'(halt), 32'd1);
    chk("hlt.cnt_unchanged", 32'(instr_cnt), 32'(saved_cnt));

    // Saturation on the 2-bit instance.
    chk("cnt2.reset_phase", 32'(phase2), 32'd0);
    chk("cnt2.reset_cnt", 32'(instr_cnt2), 32'd0);
    @(negedge clk);
    rst2_ = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 8; i++) begin
        @(posedge clk);
        #1;
        chk("cnt2.phase", 32'(phase2), 32'((i + 1) % 8));
      end
      chk("cnt2.cnt", 32'(instr_cnt2), 32'(exp_cnt2[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
